// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 strip driver.
package ws2812_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPix,
    StHigh,
    StLow,
    StLatch
  } state_e;

  localparam int unsigned DefNumLeds     = 8;
  localparam int unsigned DefBitsPerPix  = 24;
  localparam int unsigned DefT1hCyc      = 38;
  localparam int unsigned DefT1lCyc      = 20;
  localparam int unsigned DefT0hCyc      = 18;
  localparam int unsigned DefT0lCyc      = 40;
  localparam int unsigned DefLatchCyc    = 3000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Loadable down-counter; expire is high on the last cycle of a loaded phase.
module bit_timer #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/ws2812_strip_driver.sv
// WS2812 serial frame driver: one-entry pixel buffer, shift register and shared phase timer.
module ws2812_strip_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS       = DefNumLeds,
  parameter int unsigned BITS_PER_PIXEL = DefBitsPerPix,
  parameter int unsigned T1H_CYC        = DefT1hCyc,
  parameter int unsigned T1L_CYC        = DefT1lCyc,
  parameter int unsigned T0H_CYC        = DefT0hCyc,
  parameter int unsigned T0L_CYC        = DefT0lCyc,
  parameter int unsigned LATCH_CYC      = DefLatchCyc
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BITS_PER_PIXEL-1:0] pix_data,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic                      dout,
  output logic                      busy,
  output logic                      done,
  output logic                      underrun
);

  localparam int unsigned BitW   = $clog2(BITS_PER_PIXEL);
  localparam int unsigned PixW   = $clog2(NUM_LEDS + 1);
  localparam int unsigned MaxCyc = max_u(max_u(max_u(T1H_CYC, T1L_CYC), max_u(T0H_CYC, T0L_CYC)),
                                         LATCH_CYC);
  localparam int unsigned TimW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  // Timer reload values are phase length minus one: expire marks the final cycle.
  localparam logic [TimW-1:0] T1hLd   = TimW'(T1H_CYC - 1);
  localparam logic [TimW-1:0] T1lLd   = TimW'(T1L_CYC - 1);
  localparam logic [TimW-1:0] T0hLd   = TimW'(T0H_CYC - 1);
  localparam logic [TimW-1:0] T0lLd   = TimW'(T0L_CYC - 1);
  localparam logic [TimW-1:0] LatchLd = TimW'(LATCH_CYC - 1);
  localparam logic [PixW-1:0] NumLedsP = PixW'(NUM_LEDS);
  localparam logic [BitW-1:0] LastBit  = BitW'(BITS_PER_PIXEL - 1);

  state_e                    state_q, state_d;
  logic [BITS_PER_PIXEL-1:0] buf_q, buf_d;
  logic                      buf_full_q, buf_full_d;
  logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
  logic [BitW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [PixW-1:0]           pix_cnt_q, pix_cnt_d;
  logic                      underrun_q, underrun_d;
  logic                      done_q, done_d;
  logic                      tmr_load;
  logic [TimW-1:0]           tmr_val;
  logic                      tmr_expire;
  logic                      xfer;

  bit_timer #(
    .WIDTH (TimW)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  assign pix_ready = !buf_full_q && (state_q != StIdle) && (pix_cnt_q < NumLedsP);
  assign xfer      = pix_valid && pix_ready;
  // Combinational from the state register so an async reset drops the line immediately.
  assign dout      = (state_q == StHigh);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign underrun  = underrun_q;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    underrun_d = underrun_q;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    if (xfer) begin
      buf_d      = pix_data;
      buf_full_d = 1'b1;
      pix_cnt_d  = pix_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StWaitPix;
          underrun_d = 1'b0;
          bit_cnt_d  = '0;
          pix_cnt_d  = '0;
          buf_full_d = 1'b0;
        end
      end
      StWaitPix: begin
        if (buf_full_q) begin
          shift_d    = buf_q;
          buf_full_d = 1'b0;
          bit_cnt_d  = '0;
          state_d    = StHigh;
          tmr_load   = 1'b1;
          tmr_val    = buf_q[BITS_PER_PIXEL-1] ? T1hLd : T0hLd;
        end
      end
      StHigh: begin
        if (tmr_expire) begin
          state_d  = StLow;
          tmr_load = 1'b1;
          tmr_val  = shift_q[BITS_PER_PIXEL-1] ? T1lLd : T0lLd;
        end
      end
      StLow: begin
        if (tmr_expire) begin
          if (bit_cnt_q != LastBit) begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = StHigh;
            tmr_load  = 1'b1;
            tmr_val   = shift_q[BITS_PER_PIXEL-2] ? T1hLd : T0hLd;
          end else if (buf_full_q) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            bit_cnt_d  = '0;
            state_d    = StHigh;
            tmr_load   = 1'b1;
            tmr_val    = buf_q[BITS_PER_PIXEL-1] ? T1hLd : T0hLd;
          end else begin
            // Empty buffer with pixels still owed means the source fell behind.
            if (pix_cnt_q != NumLedsP) underrun_d = 1'b1;
            state_d  = StLatch;
            tmr_load = 1'b1;
            tmr_val  = LatchLd;
          end
        end
      end
      StLatch: begin
        if (tmr_expire) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: doc/ws2812_strip_driver.md
WS2812_STRIP_DRIVER -- requirements
Module: ws2812_strip_driver

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8: number of pixels sent per frame, range 1..1024.
REQ-002 SHALL have parameter BITS_PER_PIXEL, default 24: pixel width, either 24 (GRB) or 32 (GRBW).
REQ-003 SHALL have parameters T1H_CYC, T1L_CYC, T0H_CYC, T0L_CYC, defaults 38, 20, 18, 40: clk cycles of each bit phase, each at least 1.
REQ-004 SHALL have parameter LATCH_CYC, default 3000: clk cycles of low time after the last bit.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  system clock, all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous active-low reset, asserted when 0.
REQ-008 start  in  1  single-cycle request to begin a frame.
REQ-009 pix_data  in  BITS_PER_PIXEL  next pixel, sent MSB first.
REQ-010 pix_valid  in  1  pix_data is valid.
REQ-011 pix_ready  out  1  driver accepts pix_data this cycle.
REQ-012 dout  out  1  serial line to the LED strip.
REQ-013 busy  out  1  a frame is in progress (any state except IDLE).
REQ-014 done  out  1  one-cycle pulse when a frame ends.
REQ-015 underrun  out  1  sticky flag, set when a frame is aborted for lack of data.

Function
REQ-016 SHALL implement the states IDLE, WAIT_PIX, HIGH, LOW and LATCH.
REQ-017 IDLE: when start=1, SHALL go to WAIT_PIX, clear underrun, and clear the pixel and bit counters. start SHALL be ignored in every other state.
REQ-018 SHALL hold a one-entry pixel buffer; pix_ready = buffer empty AND state != IDLE AND fewer than NUM_LEDS pixels accepted this frame.
REQ-019 A transfer occurs when pix_valid & pix_ready are both 1 at a clk edge; the buffer is full from the next cycle.
REQ-020 WAIT_PIX: when the buffer is full, SHALL move the buffer into the shift register, empty the buffer, and enter HIGH on the next cycle.
REQ-021 HIGH: dout=1 for exactly T1H_CYC cycles if the current MSB is 1, else T0H_CYC cycles; then SHALL go to LOW.
REQ-022 LOW: dout=0 for exactly T1L_CYC or T0L_CYC cycles; then SHALL either shift the register left and enter HIGH, or take the pixel-boundary action in REQ-023.
REQ-023 At the end of the last bit's LOW phase: if the frame is not yet complete and the buffer is full, SHALL load the shift register with zero gap cycles; if the frame is complete, SHALL go to LATCH; if the buffer is empty, SHALL set underrun and go to LATCH.
REQ-024 LATCH: dout=0 for exactly LATCH_CYC cycles, then done=1 for one cycle and go to IDLE.
REQ-025 dout SHALL be 1 only in HIGH.
REQ-026 The high-to-low bit period SHALL be exactly (T?H_CYC + T?L_CYC) cycles, with no stall cycles between bits or pixels.
REQ-027 Counters: bit counter width = clog2(BITS_PER_PIXEL); pixel counter width = clog2(NUM_LEDS+1); no wrap within a frame.
REQ-028 A pix_valid pulse while pix_ready=0 SHALL be ignored, and pix_data SHALL not be sampled.
REQ-029 start and a handshake in the same cycle in IDLE SHALL register only the start; pix_ready is 0 in IDLE.
REQ-030 When NUM_LEDS=1, pix_ready SHALL drop after the first transfer.

Reset
REQ-031 While rst=0: state=IDLE, dout=0, busy=0, done=0, pix_ready=0, underrun=0, buffer empty, all counters 0.
REQ-032 A reset mid-frame SHALL force dout=0 at once, without waiting for a clk edge, and SHALL NOT produce a done pulse.

Structure
REQ-033 Package ws2812_pkg SHALL hold the state enum and the default timing constants.
REQ-034 SHALL instantiate one sub-module, bit_timer: a loadable down-counter that outputs expire on its last cycle. It is shared by the HIGH, LOW and LATCH phases and sized by clog2(max of all timing parameters).

Verification
Bench parameters: NUM_LEDS=2, BPP=24, T1H=4, T1L=2, T0H=2, T0L=4, LATCH=10.
REQ-035 Pixel 0xFFFFFF then 0x000000 -> 24 pulses of 4 high / 2 low, then 24 pulses of 2 high / 4 low, then 10 low cycles, then done high for 1 cycle.
REQ-036 Pixel 0xA50000 sent -> the first 8 bit periods decode to 1,0,1,0,0,1,0,1 and every bit period is exactly 6 cycles.
REQ-037 Second pixel withheld -> after bit 23 of pixel 0, underrun=1, 10 latch cycles, a done pulse, and no further HIGH phases.
REQ-038 rst driven to 0 during bit 5 of pixel 0 while HIGH -> dout=0 before the next clk edge, state IDLE, no done pulse.
REQ-039 start pulsed while busy, and pix_valid held high continuously -> the second start is ignored and exactly 2 handshakes occur per frame.
